multiplicand_queue: RTL and testbench

Parametrised multiplicand source for the sequential shift-add multiplier datapath. A DEPTH-entry FIFO buffers incoming operands. A 2*WIDTH-bit working register presents the head operand, sign- or zero-extended per operand, and shifts it left one bit on command. This lets the multiplier stream back-to-back operations without reloading.

---
 rtl/multiplicand_queue.sv | 128 ++++++++++++
 tb/tb_multiplicand_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplicand_queue.sv
// Multiplicand source for the shift-add multiplier: a small operand FIFO
// feeding a double-width working register that extends and shifts.
module multiplicand_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       W_ctrl,
    input  logic                       signed_mode,
    input  logic [WIDTH-1:0]           Multiplicand_in,
    input  logic                       Next_ctrl,
    input  logic                       Shift_ctrl,
    output logic [2*WIDTH-1:0]         Multiplicand_out,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = WIDTH + 1;

    // each entry carries its extension mode next to the data
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      mem_d [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic               valid_q, valid_d;

    logic               push;
    logic               pop;
    logic [EW-1:0]      head;
    logic [2*WIDTH-1:0] head_ext;

    // handshake decode: pop frees a slot that a same-cycle push may reuse
    always_comb begin
        pop  = !empty_q && (!valid_q || Next_ctrl);
        push = W_ctrl && (!full_q || pop);
    end

    // extend the head entry according to the mode stored with it
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (head[WIDTH])
            head_ext = {{WIDTH{head[WIDTH-1]}}, head[WIDTH-1:0]};
        else
            head_ext = {{WIDTH{1'b0}}, head[WIDTH-1:0]};
    end

    // FIFO storage, pointers, occupancy flags and sticky overflow
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = {signed_mode, Multiplicand_in};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (W_ctrl && !push)
            overflow_d = 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    // working register: load beats clear beats shift beats hold
    always_comb begin
        work_d  = work_q;
        valid_d = valid_q;
        if (pop) begin
            work_d  = head_ext;
            valid_d = 1'b1;
        end else if (Next_ctrl) begin
            work_d  = '0;
            valid_d = 1'b0;
        end else if (Shift_ctrl && valid_q) begin
            work_d = {work_q[2*WIDTH-2:0], 1'b0};
        end
    end

    // state registers, all cleared asynchronously
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            work_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            work_q     <= work_d;
            valid_q    <= valid_d;
        end
    end

    // registered outputs
    always_comb begin
        Multiplicand_out = work_q;
        out_valid        = valid_q;
        count            = count_q;
        full             = full_q;
        empty            = empty_q;
        overflow         = overflow_q;
    end

endmodule

// File: tb/tb_multiplicand_queue.sv
// Directed bench for multiplicand_queue at WIDTH=8, DEPTH=4.
module tb_multiplicand_queue;

    logic        clk = 1'b0;
    logic        Reset;
    logic        W_ctrl;
    logic        signed_mode;
    logic [7:0]  Multiplicand_in;
    logic        Next_ctrl;
    logic        Shift_ctrl;
    logic [15:0] Multiplicand_out;
    logic        out_valid;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    multiplicand_queue #(.WIDTH(8), .DEPTH(4)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .W_ctrl           (W_ctrl),
        .signed_mode      (signed_mode),
        .Multiplicand_in  (Multiplicand_in),
        .Next_ctrl        (Next_ctrl),
        .Shift_ctrl       (Shift_ctrl),
        .Multiplicand_out (Multiplicand_out),
        .out_valid        (out_valid),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        W_ctrl     = 1'b0;
        Next_ctrl  = 1'b0;
        Shift_ctrl = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic s);
        W_ctrl          = 1'b1;
        Multiplicand_in = d;
        signed_mode     = s;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] o,
                           input logic v, input logic [2:0] c,
                           input logic f, input logic e, input logic ov);
        chk({tag, "_out"}, 32'(Multiplicand_out), 32'(o));
        chk({tag, "_vld"}, 32'(out_valid), 32'(v));
        chk({tag, "_cnt"}, 32'(count), 32'(c));
        chk({tag, "_full"}, 32'(full), 32'(f));
        chk({tag, "_empty"}, 32'(empty), 32'(e));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
    endtask

    initial begin
        Reset           = 1'b1;
        signed_mode     = 1'b0;
        Multiplicand_in = '0;
        idle();
        #12;
        chk_all("reset", 16'h0000, 0, 0, 0, 1, 0);
        Reset = 1'b0;
        step();

        // sign extension, then zero extension of the same byte
        push(8'h85, 1'b1);
        step();
        chk("sx_cnt1", 32'(count), 1);
        chk("sx_vld0", 32'(out_valid), 0);
        idle();
        step();
        chk_all("sx", 16'hFF85, 1, 0, 0, 1, 0);
        Next_ctrl = 1'b1;
        push(8'h85, 1'b0);
        step();
        chk("zx_clr_out", 32'(Multiplicand_out), 0);
        chk("zx_clr_vld", 32'(out_valid), 0);
        idle();
        step();
        chk_all("zx", 16'h0085, 1, 0, 0, 1, 0);

        // shifting
        Shift_ctrl = 1'b1;
        repeat (3) step();
        chk("sh3", 32'(Multiplicand_out), 32'h0428);
        repeat (9) step();
        chk("sh12", 32'(Multiplicand_out), 32'h5000);
        repeat (4) step();
        chk("sh16", 32'(Multiplicand_out), 32'h0000);
        chk("sh16_vld", 32'(out_valid), 1);
        Shift_ctrl = 1'b0;
        Next_ctrl  = 1'b1;
        step();
        chk("sh_clr_vld", 32'(out_valid), 0);
        Next_ctrl  = 1'b0;
        Shift_ctrl = 1'b1;
        step();
        chk("sh_inv_out", 32'(Multiplicand_out), 0);
        chk("sh_inv_vld", 32'(out_valid), 0);
        idle();

        // fill past capacity: 0x06 is the sixth operand and is dropped
        for (int i = 1; i <= 6; i++) begin
            push(8'(i), 1'b0);
            step();
        end
        idle();
        chk_all("fill", 16'h0001, 1, 4, 1, 0, 1);
        for (int i = 2; i <= 5; i++) begin
            Next_ctrl = 1'b1;
            step();
            chk($sformatf("drain%0d", i), 32'(Multiplicand_out), 32'(i));
            chk($sformatf("drain%0d_cnt", i), 32'(count), 32'(5 - i));
        end
        step();
        Next_ctrl = 1'b0;
        chk_all("drain_end", 16'h0000, 0, 0, 0, 1, 1);

        // refill (pointers wrap), then push and pop while full
        for (int i = 1; i <= 5; i++) begin
            push(8'(i), 1'b0);
            step();
        end
        idle();
        chk_all("refill", 16'h0001, 1, 4, 1, 0, 1);
        push(8'h07, 1'b0);
        Next_ctrl = 1'b1;
        step();
        W_ctrl = 1'b0;
        chk_all("pp", 16'h0002, 1, 4, 1, 0, 1);
        step();
        chk("pp_d3", 32'(Multiplicand_out), 32'h03);
        step();
        chk("pp_d4", 32'(Multiplicand_out), 32'h04);
        step();
        chk("pp_d5", 32'(Multiplicand_out), 32'h05);
        step();
        chk_all("pp_d7", 16'h0007, 1, 0, 0, 1, 1);
        step();
        chk("pp_clr_vld", 32'(out_valid), 0);
        idle();

        // priority: load beats shift; clear beats shift
        push(8'hA1, 1'b0);
        step();
        idle();
        step();
        chk("pr_a1", 32'(Multiplicand_out), 32'h00A1);
        push(8'hB2, 1'b0);
        step();
        idle();
        Next_ctrl  = 1'b1;
        Shift_ctrl = 1'b1;
        step();
        chk("pr_load", 32'(Multiplicand_out), 32'h00B2);
        chk("pr_load_vld", 32'(out_valid), 1);
        step();
        chk("pr_clr", 32'(Multiplicand_out), 0);
        chk("pr_clr_vld", 32'(out_valid), 0);
        idle();

        // asynchronous reset between edges
        push(8'h11, 1'b0); step();
        push(8'h22, 1'b0); step();
        push(8'h33, 1'b0); step();
        push(8'h44, 1'b0); step();
        idle();
        chk_all("pre_rst", 16'h0011, 1, 3, 0, 0, 1);
        #2 Reset = 1'b1;
        #1;
        chk_all("async_rst", 16'h0000, 0, 0, 0, 1, 0);
        #1 Reset = 1'b0;
        push(8'h7F, 1'b1);
        step();
        chk("post_cnt", 32'(count), 1);
        idle();
        step();
        chk_all("post", 16'h007F, 1, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
